// File: rtl/read_my_action_pkg.sv
// Shared word width, no-sink ID, FSM state encoding and the action/flag consistency rule
// used by the read_my_action block and its bus interface.
package read_my_action_pkg;

    localparam int WORD_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam word_t NO_SINK_ID = word_t'(65);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE_FLAG,
        WAIT_FLAG,
        ISSUE_ACT,
        WAIT_ACT,
        ISSUE_RNG,
        WAIT_RNG,
        CLEAR,
        DONE
    } state_t;

    // An aggregating node must have picked itself (the CH), and vice versa.
    function automatic logic action_mismatch(input logic for_agg, input word_t act);
        return (for_agg && (act != NO_SINK_ID)) || (!for_agg && (act == NO_SINK_ID));
    endfunction

endpackage

// File: rtl/read_my_action_if.sv
// Request/memory/result bundle of read_my_action; master = the fetch engine, slave = its environment.
// READ_MY_ACTION_CLEAR_EN adds the flag-clear write port (wr_en, data_out).
interface read_my_action_if;
    import read_my_action_pkg::*;

    logic  start;
    word_t data_in;
    logic  rd_en;
    word_t address;
    word_t action;
    logic  forAggregation;
    word_t rng_out;
    logic  busy;
    logic  done;
    logic  mismatch;
`ifdef READ_MY_ACTION_CLEAR_EN
    logic  wr_en;
    word_t data_out;
`endif

    modport master (
        input  start,
        input  data_in,
        output rd_en,
        output address,
        output action,
        output forAggregation,
        output rng_out,
        output busy,
        output done,
        output mismatch
`ifdef READ_MY_ACTION_CLEAR_EN
        , output wr_en
        , output data_out
`endif
    );

    modport slave (
        output start,
        output data_in,
        input  rd_en,
        input  address,
        input  action,
        input  forAggregation,
        input  rng_out,
        input  busy,
        input  done,
        input  mismatch
`ifdef READ_MY_ACTION_CLEAR_EN
        , input  wr_en
        , input  data_out
`endif
    );

endinterface

// File: rtl/read_my_action_read_latency_counter.sv
// Counts the cycles spent in a WAIT state; last_o marks the edge on which read data is valid.
// Cleared during each ISSUE cycle, so every WAIT state starts counting from zero.
module read_latency_counter #(
    parameter int READ_LATENCY = 1
) (
    input  logic clock,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int CW = 3;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = en_i && (cnt_q == CW'(READ_LATENCY - 1));

endmodule

// File: rtl/read_my_action.sv
// Fetches flag, action and RNG words from memory (READ_LATENCY+1 cycles per word) and flags inconsistency.
// start is only accepted in IDLE, never queued; READ_MY_ACTION_CLEAR_EN adds a flag-clear write before done.
module read_my_action
    import read_my_action_pkg::*;
#(
    parameter logic [15:0] ACTION_ADDR  = 16'h0003,
    parameter logic [15:0] FLAG_ADDR    = 16'h0002,
    parameter logic [15:0] RNG_ADDR     = 16'h07FE,
    parameter int          READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             rst,
    read_my_action_if.master bus
);

    state_t state_q, state_d;
    word_t  action_q, action_d;
    word_t  rng_q, rng_d;
    logic   flag_q, flag_d;
    logic   mis_q, mis_d;

    logic   rd_en_s;
    word_t  addr_s;
    logic   issue_s;
    logic   wait_s;
    logic   last_s;
    logic   done_s;
`ifdef READ_MY_ACTION_CLEAR_EN
    logic   wr_en_s;
`endif

    read_latency_counter #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_latency_counter (
        .clock (clock),
        .rst   (rst),
        .clr_i (issue_s),
        .en_i  (wait_s),
        .last_o(last_s)
    );

    always_comb begin
        state_d  = state_q;
        action_d = action_q;
        rng_d    = rng_q;
        flag_d   = flag_q;
        mis_d    = mis_q;
        rd_en_s  = 1'b0;
        addr_s   = '0;
        issue_s  = 1'b0;
        wait_s   = 1'b0;
        done_s   = 1'b0;
`ifdef READ_MY_ACTION_CLEAR_EN
        wr_en_s  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = ISSUE_FLAG;
            end
            ISSUE_FLAG: begin
                rd_en_s = 1'b1;
                addr_s  = FLAG_ADDR;
                issue_s = 1'b1;
                state_d = WAIT_FLAG;
            end
            WAIT_FLAG: begin
                wait_s = 1'b1;
                if (last_s) begin
                    flag_d  = |bus.data_in;
                    state_d = ISSUE_ACT;
                end
            end
            ISSUE_ACT: begin
                rd_en_s = 1'b1;
                addr_s  = ACTION_ADDR;
                issue_s = 1'b1;
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                wait_s = 1'b1;
                if (last_s) begin
                    action_d = bus.data_in;
                    state_d  = ISSUE_RNG;
                end
            end
            ISSUE_RNG: begin
                rd_en_s = 1'b1;
                addr_s  = RNG_ADDR;
                issue_s = 1'b1;
                state_d = WAIT_RNG;
            end
            WAIT_RNG: begin
                wait_s = 1'b1;
                if (last_s) begin
                    rng_d = bus.data_in;
                    // flag and action are already registered by the time the RNG word lands
                    mis_d = action_mismatch(flag_q, action_q);
`ifdef READ_MY_ACTION_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef READ_MY_ACTION_CLEAR_EN
            CLEAR: begin
                wr_en_s = 1'b1;
                addr_s  = FLAG_ADDR;
                state_d = DONE;
            end
`endif
            DONE: begin
                done_s  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            action_q <= '0;
            rng_q    <= '0;
            flag_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            action_q <= action_d;
            rng_q    <= rng_d;
            flag_q   <= flag_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.rd_en          = rd_en_s;
    assign bus.address        = addr_s;
    assign bus.action         = action_q;
    assign bus.forAggregation = flag_q;
    assign bus.rng_out        = rng_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_s;
    assign bus.mismatch       = mis_q;
`ifdef READ_MY_ACTION_CLEAR_EN
    assign bus.wr_en          = wr_en_s;
    assign bus.data_out       = '0;
`endif

endmodule
